dsc_cache_reader: RTL
=====================

Name: dsc_cache_reader

Overview:
Read-side engine for the descriptor-cache SRAM. Accepts a burst request (start index, count), issues pipelined reads to the cache RAM while accounting for its fixed read latency, and delivers descriptors on a valid/ready stream with a last flag. A credit-limited output FIFO absorbs in-flight data so downstream back-pressure never loses a read. It sits between the descriptor cache RAM and the DMA channel sequencer.

Parameters:
WIDTH, 128, descriptor/cache word width in bits
ADDR_WIDTH, 7, cache address width (depth = 2**ADDR_WIDTH)
RD_LATENCY, 2, cycles from CACHE_REN/CACHE_RADDR to valid CACHE_RDATA (address and data registered in RAM)
FIFO_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1
CNT_WIDTH, 8, width of request count

Ports:
CLOCK  in  1  single clock, all logic rising-edge
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  burst request valid
REQ_READY  out  1  engine idle, can accept request
REQ_INDEX  in  ADDR_WIDTH  first cache index
REQ_COUNT  in  CNT_WIDTH  descriptors to read; 0 is treated as 2**CNT_WIDTH
CACHE_REN  out  1  RAM read enable (BLK_EN)
CACHE_RADDR  out  ADDR_WIDTH  RAM read address
CACHE_RDATA  in  WIDTH  RAM read data, RD_LATENCY after CACHE_REN
CACHE_DB_DETECT  in  1  RAM double-bit error, aligned with CACHE_RDATA
DSC_VALID  out  1  descriptor valid
DSC_READY  in  1  downstream accepts
DSC_DATA  out  WIDTH  descriptor word
DSC_LAST  out  1  final descriptor of burst
DSC_ERR  out  1  DB error on this word
BUSY  out  1  burst in progress or data pending

Behaviour:
- Reset (RESET=1 at clock edge): state IDLE; REQ_READY=1 on next cycle; CACHE_REN=0, CACHE_RADDR=0, DSC_VALID=0, DSC_LAST=0, DSC_ERR=0, DSC_DATA=0, BUSY=0; FIFO emptied, credit and shift pipe cleared. Reset mid-burst abandons the burst; in-flight RAM data returning after reset is discarded (valid pipe cleared).
- States: IDLE -> ISSUE on REQ_VALID&&REQ_READY (latch index, remaining=count). ISSUE -> DRAIN when last read issued. DRAIN -> IDLE when pipe empty and last word popped from FIFO. REQ_READY=1 only in IDLE.
- Issue rule: in ISSUE, CACHE_REN=1 when (inflight + fifo_count) < FIFO_DEPTH; on issue, address increments modulo 2**ADDR_WIDTH (127 -> 0 wraps), remaining decrements. A tag bit marks the issue with remaining==1 as last.
- Inflight tracking: RD_LATENCY-deep shift register of {valid,last}; at output, CACHE_RDATA/CACHE_DB_DETECT/last are pushed into FIFO. Credit check guarantees no push into a full FIFO; overflow is an assertion failure.
- Output: DSC_* driven from FIFO head (first-word fall-through, registered). Pop on DSC_VALID&&DSC_READY. Push and pop in the same cycle keep count unchanged. DSC_DATA stable while DSC_VALID&&!DSC_READY.
- Throughput: with DSC_READY held high, one descriptor per cycle sustained; first DSC_VALID at RD_LATENCY+1 cycles after request acceptance.
- DSC_ERR is per-word; no abort on error — the burst completes and the sequencer decides.
- BUSY = state!=IDLE.

Decomposition:
- Shared package dsc_cache_pkg: state enum (IDLE/ISSUE/DRAIN), default WIDTH/ADDR_WIDTH constants shared with the cache RAM wrapper, FIFO entry struct {data, err, last}.
- One sub-module: dsc_cache_reader_fifo (sync FIFO, FIFO_DEPTH x (WIDTH+2), count output, FWFT).

Test Plan:
- Single read: REQ_INDEX=5, COUNT=1, DSC_READY=1 -> one CACHE_REN at addr 5; DSC_VALID with RAM[5], DSC_LAST=1 exactly 3 cycles after acceptance; REQ_READY returns to 1.
- Streaming: INDEX=0, COUNT=16, READY=1 -> 16 consecutive REN cycles, 16 back-to-back outputs RAM[0..15], LAST only on 16th.
- Wrap: INDEX=126, COUNT=4 -> addresses 126,127,0,1 in order; data matches.
- Back-pressure: COUNT=10, DSC_READY low for 8 cycles mid-burst -> REN stalls after FIFO_DEPTH outstanding, no lost or duplicated word, order preserved.
- Error: DB_DETECT asserted with word 3 of COUNT=5 -> DSC_ERR=1 on word 3 only, burst completes with LAST on word 5.
- Reset mid-burst: RESET at cycle 4 of COUNT=20 -> next cycle DSC_VALID=0, REQ_READY=1; late RAM data not output; new request INDEX=9 COUNT=2 works normally.

Source files
------------

// File: rtl/dsc_cache_pkg.sv
// Shared types and default geometry for the descriptor-cache reader and its RAM wrapper.
package dsc_cache_pkg;

    localparam int unsigned DscWidth     = 128;
    localparam int unsigned DscAddrWidth = 7;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_t;

    typedef struct packed {
        logic [DscWidth-1:0] data;
        logic                err;
        logic                last;
    } dsc_entry_t;

endpackage

// File: rtl/dsc_cache_reader_fifo.sv
// Synchronous first-word-fall-through FIFO holding read data that has left the RAM pipe.
module dsc_cache_reader_fifo #(
    parameter int unsigned WIDTH = 130,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop     = pop && (count_q != '0);
    assign head_data  = mem[rd_ptr];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q <= count_q + CntW'(push) - CntW'(do_pop);
        end
    end

    // The upstream credit check must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_q == CntW'(DEPTH))));
        end
    end

endmodule

// File: rtl/dsc_cache_reader.sv
// Burst read engine for the descriptor cache: issues pipelined RAM reads under a FIFO
// credit limit and streams the returned words out with per-word error and last flags.
module dsc_cache_reader
    import dsc_cache_pkg::*;
#(
    parameter int unsigned WIDTH      = DscWidth,
    parameter int unsigned ADDR_WIDTH = DscAddrWidth,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_INDEX,
    input  logic [CNT_WIDTH-1:0]  REQ_COUNT,
    output logic                  CACHE_REN,
    output logic [ADDR_WIDTH-1:0] CACHE_RADDR,
    input  logic [WIDTH-1:0]      CACHE_RDATA,
    input  logic                  CACHE_DB_DETECT,
    output logic                  DSC_VALID,
    input  logic                  DSC_READY,
    output logic [WIDTH-1:0]      DSC_DATA,
    output logic                  DSC_LAST,
    output logic                  DSC_ERR,
    output logic                  BUSY
);

    localparam int unsigned FifoCntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned InflightW = $clog2(RD_LATENCY + 1);
    localparam int unsigned EntryW    = WIDTH + 2;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_last;
    logic [InflightW-1:0]  inflight;
    logic [FifoCntW-1:0]   fifo_count;
    logic                  fifo_valid;
    logic [EntryW-1:0]     head;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + InflightW'(pipe_valid[i]);
        end
    end

    // Every read in flight already owns a FIFO slot, so back-pressure can never drop data.
    assign issue      = (state == StIssue) &&
                        ((32'(inflight) + 32'(fifo_count)) < FIFO_DEPTH);
    assign issue_last = issue && (remaining == CNT_WIDTH'(1));
    assign push       = pipe_valid[RD_LATENCY-1];
    assign pop        = fifo_valid && DSC_READY;

    // A count of zero loads as zero and wraps on decrement, giving 2**CNT_WIDTH reads.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= StIdle;
            addr       <= '0;
            remaining  <= '0;
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_valid <= (pipe_valid << 1) | RD_LATENCY'(issue);
            pipe_last  <= (pipe_last << 1) | RD_LATENCY'(issue_last);
            case (state)
                StIdle: begin
                    if (REQ_VALID) begin
                        addr      <= REQ_INDEX;
                        remaining <= REQ_COUNT;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (issue_last) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if ((pipe_valid == '0) &&
                        ((fifo_count == '0) || ((fifo_count == FifoCntW'(1)) && pop))) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    dsc_cache_reader_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLOCK),
        .rst        (RESET),
        .push       (push),
        .push_data  ({CACHE_RDATA, CACHE_DB_DETECT, pipe_last[RD_LATENCY-1]}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign REQ_READY   = (state == StIdle);
    assign BUSY        = (state != StIdle);
    assign CACHE_REN   = issue;
    assign CACHE_RADDR = addr;
    assign DSC_VALID   = fifo_valid;
    assign DSC_DATA    = head[EntryW-1:2];
    assign DSC_ERR     = fifo_valid & head[1];
    assign DSC_LAST    = fifo_valid & head[0];

endmodule
